// File: rtl/bu_iq_pkg.sv
// Shared definitions for the branch-unit issue queue.
//
// Holds the datapath width constants and the packed entry record that
// every queue slot stores. The slot and the top level both import this.
package bu_iq_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int CW_W   = 4;
    localparam int OP_W   = 6;

    // One buffered branch/jump micro-op. A source is usable for issue only
    // once its rdy bit is set; until then its val field is meaningless.
    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  src1_tag;
        logic              src1_rdy;
        logic [DATA_W-1:0] src1_val;
        logic [TAG_W-1:0]  src2_tag;
        logic              src2_rdy;
        logic [DATA_W-1:0] src2_val;
        logic [TAG_W-1:0]  phydst;
        logic [CW_W-1:0]   cw;
    } iq_entry_t;

    // True when a broadcast is live and carries the tag a source waits on.
    function automatic logic tag_hit(input logic             bus_valid,
                                     input logic [TAG_W-1:0] bus_tag,
                                     input logic [TAG_W-1:0] src_tag);
        return bus_valid && (bus_tag == src_tag);
    endfunction

endpackage

// File: rtl/bu_iq_slot.sv
// One entry register of the collapsing issue queue.
//
// Each cycle the slot picks its next contents from one of three sources:
// the dispatch port, the slot directly above it (queue collapse), or
// itself (hold). The chosen contents then pass through the operand
// wakeup logic, so a source that matches a live broadcast is captured
// regardless of which path delivered it. This single post-mux wakeup is
// what gives the dispatch bypass and keeps a wakeup from being lost on
// an entry that is moving down a slot in the same cycle.
//
// Ports:
//   clk, rst        clock; clear is a synchronous kill of the entry
//   clear           invalidate the entry at the edge (reset or flush)
//   load_disp       take disp_entry (wins over shift)
//   shift           take upper_entry (queue collapse)
//   disp_entry      incoming dispatch record
//   upper_entry     contents of the next-younger slot
//   cdb0_*, cdb1_*  result broadcast buses; cdb0 wins on a double match
//   entry           registered slot contents
module bu_iq_slot
    import bu_iq_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              load_disp,
    input  logic              shift,
    input  iq_entry_t         disp_entry,
    input  iq_entry_t         upper_entry,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [DATA_W-1:0] cdb0_data,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_data,
    output iq_entry_t         entry
);

    iq_entry_t base;
    iq_entry_t next_entry;

    always_comb begin
        base = entry;
        if (load_disp) begin
            base = disp_entry;
        end else if (shift) begin
            base = upper_entry;
        end

        next_entry = base;
        if (base.valid && !base.src1_rdy) begin
            if (tag_hit(cdb0_valid, cdb0_tag, base.src1_tag)) begin
                next_entry.src1_rdy = 1'b1;
                next_entry.src1_val = cdb0_data;
            end else if (tag_hit(cdb1_valid, cdb1_tag, base.src1_tag)) begin
                next_entry.src1_rdy = 1'b1;
                next_entry.src1_val = cdb1_data;
            end
        end
        if (base.valid && !base.src2_rdy) begin
            if (tag_hit(cdb0_valid, cdb0_tag, base.src2_tag)) begin
                next_entry.src2_rdy = 1'b1;
                next_entry.src2_val = cdb0_data;
            end else if (tag_hit(cdb1_valid, cdb1_tag, base.src2_tag)) begin
                next_entry.src2_rdy = 1'b1;
                next_entry.src2_val = cdb1_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            entry <= '0;
        end else begin
            entry <= next_entry;
        end
    end

endmodule

// File: rtl/bu_issue_queue.sv
// Branch-unit issue queue and scheduler.
//
// Buffers dispatched branch/jump micro-ops in a collapsing queue (slot 0
// is oldest, valid slots are contiguous from 0), captures operands from
// two result broadcast buses, and issues at most one ready op per cycle,
// oldest first, through a registered output stage.
//
// Dispatch handshake: a dispatch transfers at an edge exactly when
// disp_valid && disp_ready && !flush in the cycle before it. disp_ready
// depends only on the registered occupancy, so it never reacts to a
// same-cycle issue; a full queue refuses dispatch even when it is about
// to issue. The issue side has no back-pressure: ex_en is a one-cycle
// valid pulse per issued op.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   flush                  kill all entries and any pending issue
//   disp_*                 dispatch request and op fields
//   cdb0_*, cdb1_*         result broadcast buses
//   ex_en, ex_*            issued op to the branch unit
//   occupancy              number of valid entries
module bu_issue_queue
    import bu_iq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OP_W-1:0]            disp_op,
    input  logic [DATA_W-1:0]          disp_imm,
    input  logic [DATA_W-1:0]          disp_pc,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [DATA_W-1:0]          disp_src1_val,
    input  logic [DATA_W-1:0]          disp_src2_val,
    input  logic [TAG_W-1:0]           disp_phydst,
    input  logic [CW_W-1:0]            disp_cw,
    input  logic                       cdb0_valid,
    input  logic                       cdb1_valid,
    input  logic [TAG_W-1:0]           cdb0_tag,
    input  logic [TAG_W-1:0]           cdb1_tag,
    input  logic [DATA_W-1:0]          cdb0_data,
    input  logic [DATA_W-1:0]          cdb1_data,
    output logic                       ex_en,
    output logic [OP_W-1:0]            ex_op,
    output logic [DATA_W-1:0]          ex_imm,
    output logic [DATA_W-1:0]          ex_src1,
    output logic [DATA_W-1:0]          ex_src2,
    output logic [DATA_W-1:0]          ex_pc,
    output logic [TAG_W-1:0]           ex_phydst,
    output logic [CW_W-1:0]            ex_cw,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH+1);

    iq_entry_t        slot_q  [DEPTH];
    iq_entry_t        upper_q [DEPTH];
    iq_entry_t        disp_entry;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] load_disp;
    logic [DEPTH-1:0] shift;

    logic              sel_valid;
    logic [CNT_W-1:0]  sel_idx;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_imm;
    logic [DATA_W-1:0] sel_pc;
    logic [DATA_W-1:0] sel_src1;
    logic [DATA_W-1:0] sel_src2;
    logic [TAG_W-1:0]  sel_phydst;
    logic [CW_W-1:0]   sel_cw;

    logic              accept;
    logic              clear;
    logic [CNT_W-1:0]  disp_slot;

    assign disp_ready = (occupancy != CNT_W'(DEPTH));
    assign accept     = disp_valid && disp_ready && !flush;
    assign clear      = rst || flush;
    // After the same-cycle issue collapses the queue, the first free slot
    // is one lower than the registered count.
    assign disp_slot  = occupancy - CNT_W'(sel_valid);

    always_comb begin
        disp_entry          = '0;
        disp_entry.valid    = 1'b1;
        disp_entry.op       = disp_op;
        disp_entry.imm      = disp_imm;
        disp_entry.pc       = disp_pc;
        disp_entry.src1_tag = disp_src1_tag;
        disp_entry.src1_rdy = disp_src1_rdy;
        disp_entry.src1_val = disp_src1_val;
        disp_entry.src2_tag = disp_src2_tag;
        disp_entry.src2_rdy = disp_src2_rdy;
        disp_entry.src2_val = disp_src2_val;
        disp_entry.phydst   = disp_phydst;
        disp_entry.cw       = disp_cw;
    end

    // Oldest-first select: scan from the top down so the last hit written
    // is the lowest ready index.
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        sel_op     = '0;
        sel_imm    = '0;
        sel_pc     = '0;
        sel_src1   = '0;
        sel_src2   = '0;
        sel_phydst = '0;
        sel_cw     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_valid  = 1'b1;
                sel_idx    = CNT_W'(i);
                sel_op     = slot_q[i].op;
                sel_imm    = slot_q[i].imm;
                sel_pc     = slot_q[i].pc;
                sel_src1   = slot_q[i].src1_val;
                sel_src2   = slot_q[i].src2_val;
                sel_phydst = slot_q[i].phydst;
                sel_cw     = slot_q[i].cw;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == DEPTH - 1) begin : g_last
            assign upper_q[i] = '0;
        end else begin : g_inner
            assign upper_q[i] = slot_q[i+1];
        end

        assign ready_vec[i] = slot_q[i].valid && slot_q[i].src1_rdy && slot_q[i].src2_rdy;
        assign load_disp[i] = accept && (disp_slot == CNT_W'(i));
        // Every slot at or above the issued one takes its upper neighbour.
        assign shift[i]     = sel_valid && (CNT_W'(i) >= sel_idx);

        bu_iq_slot u_slot (
            .clk         (clk),
            .clear       (clear),
            .load_disp   (load_disp[i]),
            .shift       (shift[i]),
            .disp_entry  (disp_entry),
            .upper_entry (upper_q[i]),
            .cdb0_valid  (cdb0_valid),
            .cdb0_tag    (cdb0_tag),
            .cdb0_data   (cdb0_data),
            .cdb1_valid  (cdb1_valid),
            .cdb1_tag    (cdb1_tag),
            .cdb1_data   (cdb1_data),
            .entry       (slot_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy - CNT_W'(sel_valid) + CNT_W'(accept);
        end
    end

    // Flush drops the pending issue but leaves the data fields alone;
    // only reset zeroes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_en     <= 1'b0;
            ex_op     <= '0;
            ex_imm    <= '0;
            ex_src1   <= '0;
            ex_src2   <= '0;
            ex_pc     <= '0;
            ex_phydst <= '0;
            ex_cw     <= '0;
        end else if (flush) begin
            ex_en <= 1'b0;
        end else begin
            ex_en <= sel_valid;
            if (sel_valid) begin
                ex_op     <= sel_op;
                ex_imm    <= sel_imm;
                ex_src1   <= sel_src1;
                ex_src2   <= sel_src2;
                ex_pc     <= sel_pc;
                ex_phydst <= sel_phydst;
                ex_cw     <= sel_cw;
            end
        end
    end

endmodule

// File: tb/tb_bu_issue_queue.sv
// Self-checking bench for bu_issue_queue.
//
// The reference model is an ordered list of waiting ops; each cycle it
// removes the oldest op with both sources available, wakes the rest from
// the broadcast buses and appends an accepted dispatch. Each removal
// pushes the expected issue record onto exp_q; an independent monitor
// pops and compares whenever the DUT raises ex_en.
module tb_bu_issue_queue;
    import bu_iq_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int EXP_W = OP_W + 4*DATA_W + TAG_W + CW_W;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [DATA_W-1:0] disp_imm;
    logic [DATA_W-1:0] disp_pc;
    logic [TAG_W-1:0]  disp_src1_tag;
    logic [TAG_W-1:0]  disp_src2_tag;
    logic              disp_src1_rdy;
    logic              disp_src2_rdy;
    logic [DATA_W-1:0] disp_src1_val;
    logic [DATA_W-1:0] disp_src2_val;
    logic [TAG_W-1:0]  disp_phydst;
    logic [CW_W-1:0]   disp_cw;
    logic              cdb0_valid;
    logic              cdb1_valid;
    logic [TAG_W-1:0]  cdb0_tag;
    logic [TAG_W-1:0]  cdb1_tag;
    logic [DATA_W-1:0] cdb0_data;
    logic [DATA_W-1:0] cdb1_data;
    logic              ex_en;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_src1;
    logic [DATA_W-1:0] ex_src2;
    logic [DATA_W-1:0] ex_pc;
    logic [TAG_W-1:0]  ex_phydst;
    logic [CW_W-1:0]   ex_cw;
    logic [CNT_W-1:0]  occupancy;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  t1;
        bit                r1;
        logic [DATA_W-1:0] v1;
        logic [TAG_W-1:0]  t2;
        bit                r2;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  dst;
        logic [CW_W-1:0]   cw;
    } model_op_t;

    model_op_t        model_q[$];
    logic [EXP_W-1:0] exp_q[$];
    int               n_vec;
    int               n_err;

    bu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_op       (disp_op),
        .disp_imm      (disp_imm),
        .disp_pc       (disp_pc),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_src1_val (disp_src1_val),
        .disp_src2_val (disp_src2_val),
        .disp_phydst   (disp_phydst),
        .disp_cw       (disp_cw),
        .cdb0_valid    (cdb0_valid),
        .cdb1_valid    (cdb1_valid),
        .cdb0_tag      (cdb0_tag),
        .cdb1_tag      (cdb1_tag),
        .cdb0_data     (cdb0_data),
        .cdb1_data     (cdb1_data),
        .ex_en         (ex_en),
        .ex_op         (ex_op),
        .ex_imm        (ex_imm),
        .ex_src1       (ex_src1),
        .ex_src2       (ex_src2),
        .ex_pc         (ex_pc),
        .ex_phydst     (ex_phydst),
        .ex_cw         (ex_cw),
        .occupancy     (occupancy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [EXP_W-1:0] act,
                         input logic [EXP_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack(input model_op_t e);
        return {e.op, e.imm, e.pc, e.v1, e.v2, e.dst, e.cw};
    endfunction

    function automatic logic [EXP_W-1:0] dut_out();
        return {ex_op, ex_imm, ex_pc, ex_src1, ex_src2, ex_phydst, ex_cw};
    endfunction

    function automatic model_op_t wake(input model_op_t e);
        model_op_t w = e;
        if (!w.r1) begin
            if (cdb0_valid && cdb0_tag == w.t1) begin
                w.r1 = 1'b1; w.v1 = cdb0_data;
            end else if (cdb1_valid && cdb1_tag == w.t1) begin
                w.r1 = 1'b1; w.v1 = cdb1_data;
            end
        end
        if (!w.r2) begin
            if (cdb0_valid && cdb0_tag == w.t2) begin
                w.r2 = 1'b1; w.v2 = cdb0_data;
            end else if (cdb1_valid && cdb1_tag == w.t2) begin
                w.r2 = 1'b1; w.v2 = cdb1_data;
            end
        end
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        rst        = 1'b0;
        flush      = 1'b0;
        disp_valid = 1'b0;
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] pc,
                            input logic [TAG_W-1:0] t1, input bit r1, input logic [DATA_W-1:0] v1,
                            input logic [TAG_W-1:0] t2, input bit r2, input logic [DATA_W-1:0] v2);
        disp_valid    = 1'b1;
        disp_op       = op;
        disp_imm      = $urandom;
        disp_pc       = pc;
        disp_src1_tag = t1;
        disp_src1_rdy = r1;
        disp_src1_val = v1;
        disp_src2_tag = t2;
        disp_src2_rdy = r2;
        disp_src2_val = v2;
        disp_phydst   = TAG_W'($urandom);
        disp_cw       = CW_W'($urandom);
    endtask

    task automatic rand_disp();
        set_disp(OP_W'($urandom), $urandom,
                 TAG_W'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), $urandom,
                 TAG_W'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic set_cdb0(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        cdb0_valid = 1'b1; cdb0_tag = tag; cdb0_data = data;
    endtask

    task automatic set_cdb1(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        cdb1_valid = 1'b1; cdb1_tag = tag; cdb1_data = data;
    endtask

    // Checks the registered status, advances the model with the inputs
    // currently driven, then crosses one clock edge.
    task automatic cycle();
        model_op_t e;
        int        sel;
        int        size_before;
        check("occupancy", EXP_W'(occupancy), EXP_W'(model_q.size()));
        check("disp_ready", EXP_W'(disp_ready), EXP_W'(model_q.size() != DEPTH));
        if (rst || flush) begin
            model_q.delete();
        end else begin
            size_before = model_q.size();
            sel = -1;
            for (int i = 0; i < model_q.size(); i++) begin
                if (sel < 0 && model_q[i].r1 && model_q[i].r2) sel = i;
            end
            if (sel >= 0) begin
                exp_q.push_back(pack(model_q[sel]));
                model_q.delete(sel);
            end
            foreach (model_q[i]) model_q[i] = wake(model_q[i]);
            if (disp_valid && size_before != DEPTH) begin
                e.op = disp_op;   e.imm = disp_imm;  e.pc = disp_pc;
                e.t1 = disp_src1_tag; e.r1 = disp_src1_rdy; e.v1 = disp_src1_val;
                e.t2 = disp_src2_tag; e.r2 = disp_src2_rdy; e.v2 = disp_src2_val;
                e.dst = disp_phydst; e.cw = disp_cw;
                model_q.push_back(wake(e));
            end
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (ex_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL issue_unexpected: got ex_en=1 pc=%h expected no issue", ex_pc);
            end else begin
                check("issue", dut_out(), exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        disp_op = '0; disp_imm = '0; disp_pc = '0;
        disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
        disp_src1_val = '0; disp_src2_val = '0; disp_phydst = '0; disp_cw = '0;
        cdb0_tag = '0; cdb1_tag = '0; cdb0_data = '0; cdb1_data = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        idle();
        check("reset_occupancy", EXP_W'(occupancy), '0);
        check("reset_disp_ready", EXP_W'(disp_ready), EXP_W'(1));
        check("reset_ex_en", EXP_W'(ex_en), '0);
        check("reset_ex_data", dut_out(), '0);

        // Single ready op flows through with two cycles of latency.
        set_disp(6'h04, 32'h100, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd5);
        cycle();
        repeat (3) cycle();

        // Mid-run reset zeroes the output fields that the last issue left.
        rst = 1'b1;
        cycle();
        check("rst_ex_en", EXP_W'(ex_en), '0);
        check("rst_ex_data", dut_out(), '0);

        // Younger ready op overtakes an older waiting one.
        set_disp(6'h01, 32'h200, 6'd12, 1'b0, 32'h0, 6'd3, 1'b1, 32'h33);
        cycle();
        set_disp(6'h02, 32'h204, 6'd4, 1'b1, 32'h44, 6'd5, 1'b1, 32'h55);
        cycle();
        cycle();
        set_cdb1(6'd12, 32'hDEAD);
        cycle();
        repeat (3) cycle();

        // Fill with waiting ops, refuse an extra dispatch, wake slot 2 first.
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(OP_W'(8 + i), 32'h300 + 32'(4 * i), TAG_W'(20 + i), 1'b0, 32'h0,
                     6'd6, 1'b1, 32'h66);
            cycle();
        end
        set_disp(6'h3F, 32'h3FC, 6'd7, 1'b1, 32'h77, 6'd7, 1'b1, 32'h77);
        cycle();
        set_cdb0(6'd22, 32'h2222);
        cycle();
        cycle();
        set_cdb0(6'd20, 32'h2020);
        set_cdb1(6'd23, 32'h2323);
        cycle();
        set_cdb0(6'd21, 32'h2121);
        cycle();
        repeat (4) cycle();

        // Dispatch bypass and cdb0 priority on a double match.
        set_disp(6'h05, 32'h400, 6'd8, 1'b1, 32'h88, 6'd9, 1'b0, 32'h0);
        set_cdb0(6'd9, 32'h40);
        cycle();
        repeat (2) cycle();
        set_disp(6'h06, 32'h404, 6'd8, 1'b1, 32'h88, 6'd9, 1'b0, 32'h0);
        cycle();
        set_cdb0(6'd9, 32'h40);
        set_cdb1(6'd9, 32'h80);
        cycle();
        repeat (3) cycle();

        // Flush on the cycle the oldest of three ready ops is selected.
        for (int i = 0; i < 3; i++) begin
            set_disp(OP_W'(16 + i), 32'h500 + 32'(4 * i), 6'd30, 1'b0, 32'h0, 6'd6, 1'b1, 32'h6);
            cycle();
        end
        set_cdb0(6'd30, 32'h3030);
        cycle();
        flush = 1'b1;
        set_disp(6'h1F, 32'h5FC, 6'd1, 1'b1, 32'h1, 6'd1, 1'b1, 32'h1);
        cycle();
        repeat (3) cycle();

        // Full queue with the oldest ready: dispatch refused twice, then taken.
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(OP_W'(32 + i), 32'h600 + 32'(4 * i), TAG_W'(40 + i), 1'b0, 32'h0,
                     6'd6, 1'b1, 32'h6);
            cycle();
        end
        set_disp(6'h2A, 32'h6F0, 6'd1, 1'b1, 32'hA1, 6'd1, 1'b1, 32'hA2);
        set_cdb0(6'd40, 32'h4040);
        cycle();
        set_disp(6'h2A, 32'h6F0, 6'd1, 1'b1, 32'hA1, 6'd1, 1'b1, 32'hA2);
        cycle();
        set_disp(6'h2A, 32'h6F0, 6'd1, 1'b1, 32'hA1, 6'd1, 1'b1, 32'hA2);
        cycle();
        set_cdb0(6'd41, 32'h4141);
        set_cdb1(6'd42, 32'h4242);
        cycle();
        set_cdb0(6'd43, 32'h4343);
        cycle();
        repeat (6) cycle();

        // Random traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 60) rand_disp();
            if ($urandom_range(0, 99) < 40) set_cdb0(TAG_W'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 99) < 40) set_cdb1(TAG_W'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 99) < 3) flush = 1'b1;
            cycle();
        end

        // Drain: broadcast every random tag so nothing is left waiting.
        for (int t = 0; t < 16; t += 2) begin
            set_cdb0(TAG_W'(t), $urandom);
            set_cdb1(TAG_W'(t + 1), $urandom);
            cycle();
        end
        repeat (DEPTH + 4) cycle();
        check("drained_expected", EXP_W'(exp_q.size()), '0);
        check("drained_model", EXP_W'(model_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
